i2c_target: RTL
===============

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter I2C_ADDR, default 7'h50, 7-bit target address matched in the address phase.
REQ-002 SHALL have port sys_clk_i  input  1  system clock, 100 MHz; all logic on rising edge.
REQ-003 SHALL have port sys_rst_i  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port scl_i  input  1  bus SCL, asynchronous to sys_clk_i.
REQ-005 SHALL have port sda_i  input  1  bus SDA, asynchronous to sys_clk_i.
REQ-006 SHALL have port sda_oe_o  output  1  1 = pull SDA low, 0 = release (open-drain).
REQ-007 SHALL have port reg_addr_o  output  8  register pointer.
REQ-008 SHALL have port reg_wdata_o  output  8  write data, valid while reg_wr_o=1.
REQ-009 SHALL have port reg_wr_o  output  1  one-cycle register write strobe.
REQ-010 SHALL have port reg_rd_o  output  1  one-cycle strobe; rd_data_i is captured in the same cycle.
REQ-011 SHALL have port rd_data_i  input  8  register read data.
REQ-012 SHALL have port busy_o  output  1  high from an addressed START until STOP or return to IDLE.

Function
REQ-013 SHALL pass scl_i and sda_i through 2-flop synchronizers; edges are detected on the synchronized signals.
REQ-014 SHALL detect START as synced SDA 1->0 while synced SCL=1, and STOP as synced SDA 1->0 inverse (0->1) while synced SCL=1.
REQ-015 SHALL use FSM states IDLE, ADDR, ADDR_ACK, PTR, WR, WR_ACK, RD, RD_ACK.
REQ-016 SHALL enter ADDR on START from any state, including a repeated START mid-byte; bit counter clears to 0.
REQ-017 SHALL enter IDLE on STOP from any state, release SDA and clear busy_o in the same cycle.
REQ-018 SHALL sample data bits MSB first on synced SCL rising edge and change sda_oe_o only on synced SCL falling edge.
REQ-019 ADDR: after 8 bits, on address match SHALL enter ADDR_ACK and drive SDA low for the 9th clock; on mismatch SHALL return to IDLE with SDA released (NACK).
REQ-020 ADDR_ACK with R/W=0 SHALL go to PTR; with R/W=1 SHALL go to RD.
REQ-021 PTR: first write byte SHALL load reg_addr_o, then ACK, then WR.
REQ-022 WR: each byte SHALL produce reg_wr_o=1 for one cycle at the 8th SCL rising edge with reg_wdata_o=byte and the current pointer, then ACK (WR_ACK), then pointer+1.
REQ-023 Entry to RD SHALL pulse reg_rd_o at the ACK-ending SCL falling edge and load the shift register from rd_data_i; bit 7 SHALL be driven immediately (sda_oe_o = ~bit).
REQ-024 RD_ACK SHALL release SDA, sample master ACK at the 9th SCL rise; ACK(0) -> pointer+1 and RD, NACK(1) -> IDLE.
REQ-025 Pointer SHALL wrap 8'hFF -> 8'h00 with no error.
REQ-026 A repeated START after PTR SHALL retain the pointer (combined write-pointer/read).
REQ-027 No clock stretching; SCL is never driven.

Reset
REQ-028 On sys_rst_i=0 SHALL asynchronously force: state IDLE, sda_oe_o=0, reg_wr_o=0, reg_rd_o=0, busy_o=0, reg_addr_o=8'h00, reg_wdata_o=8'h00, synchronizers=1.
REQ-029 Reset deassertion mid-transaction SHALL leave the block in IDLE waiting for a new START.

Configuration
REQ-030 With I2C_TARGET_GLITCH_FILTER_EN defined, SHALL add a 3-sample majority filter after each synchronizer (2 extra cycles latency; pulses <=1 cycle rejected).
REQ-031 Without I2C_TARGET_GLITCH_FILTER_EN, synchronized signals SHALL be used directly.

Verification
REQ-032 START, 0xA0, 0x10, 0x5A, STOP -> ACK on all 3 bytes; one reg_wr_o with addr 8'h10, data 8'h5A; busy_o low after STOP.
REQ-033 START, 0xA2 (wrong address) -> sda_oe_o stays 0 at 9th clock; FSM in IDLE; no strobes.
REQ-034 START, 0xA0, 0x02, Sr, 0xA1, read 2 bytes (ACK, NACK), rd_data_i=8'h3C then 8'hC3 -> bus bits 00111100, 11000011; reg_rd_o pulses with addr 02 then 03.
REQ-035 Write pointer 0xFF, write 0x11, 0x22 -> writes to 8'hFF then 8'h00.
REQ-036 STOP injected after bit 4 of a write byte -> no reg_wr_o, SDA released, IDLE; next START addressed normally.
REQ-037 sys_rst_i pulsed low during RD with sda_oe_o=1 -> sda_oe_o=0 within the same cycle, all outputs at reset values.

Source files
------------

// File: rtl/i2c_target.sv
// ---------------------------------------------------------------------------
// i2c_target
//   I2C target (slave) that exposes an 8-bit register pointer and a simple
//   one-cycle read/write strobe interface to a local register file.
//   Write transfer : START, addr+W, pointer byte, data bytes..., STOP
//   Read transfer  : START, addr+R, data bytes... (pointer auto-increments)
//   Combined       : START, addr+W, pointer, Sr, addr+R, data bytes..., STOP
//
// Parameters
//   I2C_ADDR     7-bit target address (default 7'h50)
//
// Ports
//   sys_clk_i    system clock, all logic on rising edge
//   sys_rst_i    asynchronous active-low reset
//   scl_i/sda_i  bus lines, asynchronous to sys_clk_i
//   sda_oe_o     1 = pull SDA low, 0 = release (open drain)
//   reg_addr_o   register pointer
//   reg_wdata_o  write data, valid while reg_wr_o = 1
//   reg_wr_o     one-cycle register write strobe
//   reg_rd_o     one-cycle read strobe; rd_data_i captured in that cycle
//   rd_data_i    register read data
//   busy_o       high from an address match until STOP / return to IDLE
//
// Configuration
//   I2C_TARGET_GLITCH_FILTER_EN  adds a 3-sample majority filter after each
//                                synchronizer (2 extra cycles of latency).
// ---------------------------------------------------------------------------
module i2c_target #(
  parameter logic [6:0] I2C_ADDR = 7'h50
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_wr_o,
  output logic       reg_rd_o,
  input  logic [7:0] rd_data_i,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    PTR      = 3'd3,
    WR       = 3'd4,
    WR_ACK   = 3'd5,
    RD       = 3'd6,
    RD_ACK   = 3'd7
  } state_t;

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       w_scl;
  logic       w_sda;
  logic       r_scl_prev;
  logic       r_sda_prev;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;

  state_t     r_state,  w_state_nxt;
  logic [3:0] r_cnt,    w_cnt_nxt;
  logic [7:0] r_shift,  w_shift_nxt;
  logic       r_rw,     w_rw_nxt;
  logic [7:0] r_ptr,    w_ptr_nxt;
  logic [7:0] r_wdata,  w_wdata_nxt;
  logic       r_wr,     w_wr_nxt;
  logic       r_rd,     w_rd_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic       r_busy,   w_busy_nxt;

  // Two-flop synchronizers; idle-high reset matches a released bus.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_i};
      r_sda_sync <= {r_sda_sync[0], sda_i};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] r_scl_hist;
  logic [1:0] r_sda_hist;
  logic       r_scl_filt;
  logic       r_sda_filt;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Majority vote over the last three synchronized samples.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_scl_hist <= 2'b11;
      r_sda_hist <= 2'b11;
      r_scl_filt <= 1'b1;
      r_sda_filt <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
      r_scl_filt <= maj3(r_scl_sync[1], r_scl_hist[0], r_scl_hist[1]);
      r_sda_filt <= maj3(r_sda_sync[1], r_sda_hist[0], r_sda_hist[1]);
    end
  end

  assign w_scl = r_scl_filt;
  assign w_sda = r_sda_filt;
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  // Previous-sample registers for edge and START/STOP detection.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  // SCL must be high in both samples so a simultaneous SCL/SDA change is not
  // mistaken for a START or STOP.
  assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

  // State and datapath registers.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_shift  <= 8'h00;
      r_rw     <= 1'b0;
      r_ptr    <= 8'h00;
      r_wdata  <= 8'h00;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_sda_oe <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shift  <= w_shift_nxt;
      r_rw     <= w_rw_nxt;
      r_ptr    <= w_ptr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_wr     <= w_wr_nxt;
      r_rd     <= w_rd_nxt;
      r_sda_oe <= w_sda_oe_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shift_nxt  = r_shift;
    w_rw_nxt     = r_rw;
    w_ptr_nxt    = r_ptr;
    w_wdata_nxt  = r_wdata;
    w_wr_nxt     = 1'b0;
    w_rd_nxt     = 1'b0;
    w_sda_oe_nxt = r_sda_oe;
    w_busy_nxt   = r_busy;

    // The read strobe cycle is the cycle rd_data_i is captured; the first
    // bit goes onto the bus straight away.
    if (r_rd) begin
      w_shift_nxt  = rd_data_i;
      w_sda_oe_nxt = ~rd_data_i[7];
    end else begin
      w_shift_nxt  = r_shift;
    end

    if (w_stop) begin
      w_state_nxt  = IDLE;
      w_cnt_nxt    = 4'd0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = ADDR;
      w_cnt_nxt    = 4'd0;
      w_sda_oe_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_sda_oe_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
        end
        ADDR: begin
          if (w_scl_rise && (r_cnt < 4'd8)) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            w_cnt_nxt   = r_cnt + 4'd1;
          end else if (w_scl_fall && (r_cnt == 4'd8)) begin
            w_cnt_nxt = 4'd0;
            if (r_shift[7:1] == I2C_ADDR) begin
              w_state_nxt  = ADDR_ACK;
              w_rw_nxt     = r_shift[0];
              w_sda_oe_nxt = 1'b1;
              w_busy_nxt   = 1'b1;
            end else begin
              w_state_nxt  = IDLE;
              w_sda_oe_nxt = 1'b0;
              w_busy_nxt   = 1'b0;
            end
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        ADDR_ACK: begin
          // End of the ACK clock: hand over to pointer write or data read.
          if (w_scl_fall) begin
            w_cnt_nxt = 4'd0;
            if (r_rw) begin
              w_state_nxt = RD;
              w_rd_nxt    = 1'b1;
            end else begin
              w_state_nxt  = PTR;
              w_sda_oe_nxt = 1'b0;
            end
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        PTR: begin
          // Counts 0..7 shift data, 8 = drive ACK, 9 = ACK clock in progress.
          if (w_scl_rise && (r_cnt < 4'd8)) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_ptr_nxt = {r_shift[6:0], w_sda};
            end else begin
              w_ptr_nxt = r_ptr;
            end
          end else if (w_scl_fall && (r_cnt == 4'd8)) begin
            w_sda_oe_nxt = 1'b1;
            w_cnt_nxt    = 4'd9;
          end else if (w_scl_fall && (r_cnt == 4'd9)) begin
            w_sda_oe_nxt = 1'b0;
            w_cnt_nxt    = 4'd0;
            w_state_nxt  = WR;
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        WR: begin
          if (w_scl_rise && (r_cnt < 4'd8)) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_wr_nxt    = 1'b1;
              w_wdata_nxt = {r_shift[6:0], w_sda};
            end else begin
              w_wr_nxt    = 1'b0;
            end
          end else if (w_scl_fall && (r_cnt == 4'd8)) begin
            w_sda_oe_nxt = 1'b1;
            w_cnt_nxt    = 4'd0;
            w_state_nxt  = WR_ACK;
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        WR_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe_nxt = 1'b0;
            w_ptr_nxt    = r_ptr + 8'd1;
            w_state_nxt  = WR;
          end else begin
            w_ptr_nxt = r_ptr;
          end
        end
        RD: begin
          if (w_scl_rise && (r_cnt < 4'd8)) begin
            w_cnt_nxt = r_cnt + 4'd1;
          end else if (w_scl_fall && (r_cnt == 4'd8)) begin
            w_sda_oe_nxt = 1'b0;
            w_cnt_nxt    = 4'd0;
            w_state_nxt  = RD_ACK;
          end else if (w_scl_fall && (r_cnt != 4'd0)) begin
            w_shift_nxt  = {r_shift[6:0], 1'b0};
            w_sda_oe_nxt = ~r_shift[6];
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        RD_ACK: begin
          // r_cnt = 1 marks a master ACK seen on this clock.
          if (w_scl_rise) begin
            if (!w_sda) begin
              w_ptr_nxt = r_ptr + 8'd1;
              w_cnt_nxt = 4'd1;
            end else begin
              w_state_nxt = IDLE;
              w_busy_nxt  = 1'b0;
            end
          end else if (w_scl_fall && (r_cnt == 4'd1)) begin
            w_rd_nxt    = 1'b1;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = RD;
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        default: begin
          w_state_nxt  = IDLE;
          w_sda_oe_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe_o    = r_sda_oe;
  assign reg_addr_o  = r_ptr;
  assign reg_wdata_o = r_wdata;
  assign reg_wr_o    = r_wr;
  assign reg_rd_o    = r_rd;
  assign busy_o      = r_busy;

endmodule
